mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
- Initiator side of the MDU valid/ready interface; sits in the execute stage between decode/EX operands and the MDU.
- Accepts M-extension instructions from EX and issues exactly one single-cycle request per instruction.
- Holds op and operands stable for the whole MDU operation and stalls the pipeline until the result returns.
- Presents the result to writeback, drains requests killed by a flush, and flags a hung MDU with a timeout.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT/DRAIN before abort; counter width = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- ex_valid_i  in  1  EX holds an M-extension instruction
- ex_op_i  in  3  MDU op code (MUL..REMU, 000..111)
- ex_rs1_i  in  32  operand 1
- ex_rs2_i  in  32  operand 2
- ex_rd_addr_i  in  5  destination register
- flush_i  in  1  kill instruction currently in EX
- stall_o  out  1  hold EX/upstream stages
- mdu_valid_o  out  1  request to MDU; single-cycle pulse
- mdu_op_o  out  3  op to MDU; held stable
- mdu_rs1_o  out  32  operand to MDU; held stable
- mdu_rs2_o  out  32  operand to MDU; held stable
- mdu_ready_i  in  1  MDU result-valid pulse
- mdu_rd_i  in  32  MDU result; valid while mdu_ready_i=1
- wb_valid_o  out  1  result valid to writeback
- wb_rd_addr_o  out  5  destination register
- wb_data_o  out  32  result
- err_timeout_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE immediately.
  - All registered outputs go to 0: mdu_*_o, wb_*_o, err_timeout_o, timeout counter.
  - Reset mid-operation abandons the transaction; the MDU is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - If ex_valid_i & !flush_i: latch op, rs1, rs2, rd_addr into the mdu_*_o / rd registers; go to ISSUE.
  - If flush_i is high, the request is ignored.
- ISSUE:
  - mdu_valid_o=1 for exactly this cycle.
  - Counter cleared; go to WAIT, or DRAIN if flush_i.
  - Asserting valid once is mandatory: the MDU re-triggers if valid is held.
- WAIT:
  - Counter increments each cycle.
  - On mdu_ready_i: capture mdu_rd_i into wb_data_o, go to DONE.
  - On flush_i without mdu_ready_i: go to DRAIN.
  - On flush_i with mdu_ready_i in the same cycle: go to IDLE, result discarded.
  - On counter==TIMEOUT_CYCLES: pulse err_timeout_o, go to IDLE, no writeback.
- DONE:
  - wb_valid_o = !flush_i (combinational gate on registered state).
  - stall_o=0, so EX advances at the end of this cycle. Go to IDLE.
- DRAIN:
  - Waits for mdu_ready_i with the counter running; result discarded.
  - On mdu_ready_i go to IDLE. On timeout pulse err_timeout_o and go to IDLE.
- stall_o (combinational):
  - 1 in IDLE when ex_valid_i & !flush_i.
  - 1 in ISSUE and WAIT.
  - In DRAIN, equals ex_valid_i (a new instruction waits until the drain completes).
  - 0 in DONE.
- mdu_op_o/rs1/rs2 change only on IDLE acceptance; they stay constant through WAIT/DRAIN, including the mdu_ready_i cycle.
- Latency: MDU latency + 3 cycles (accept, issue, done), from the EX-valid cycle to the wb_valid_o cycle.
- Back-to-back instructions: the second is accepted in the IDLE cycle after DONE; no bubble beyond that.

Optional Feature:
- MDU_RESULT_CACHE_EN
  - Defined: stores {op, rs1, rs2, result, valid} from the last non-flushed completion.
  - IDLE acceptance that matches a valid entry goes directly to DONE with the cached result; no mdu_valid_o.
  - The cache is invalidated on reset and on timeout.
  - Undefined: every instruction is issued to the MDU; no cache storage.

Decomposition:
- Shared package mdu_pkg holds:
  - op-code localparams MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - the mdu_issue_state_t enum;
  - the request struct {op, rs1, rs2}.
- The MDU itself should migrate its op codes to mdu_pkg.
- No sub-module: the timeout counter and cache are small and stay inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> one mdu_valid_o cycle; stall_o high until DONE; wb_valid_o with wb_data_o=0xFFFFFFEB, correct rd.
- DIVU 100/7 then REM 0xFFFFFFF9 % 2 back-to-back -> wb_data 0x0000000E, then 0xFFFFFFFF; operands stable across each WAIT.
- DIV issued, flush_i 5 cycles into WAIT -> no wb_valid_o; new MUL waits in DRAIN with stall_o=1; it is issued only after the MDU ready pulse.
- TIMEOUT_CYCLES=8, mdu_ready_i tied 0 -> err_timeout_o pulses 9 cycles after ISSUE; state IDLE; stall_o drops.
- rst_n low mid-WAIT -> all outputs 0 asynchronously; after release a MULHU 0xFFFFFFFF*2 returns 0x00000001.
- With MDU_RESULT_CACHE_EN, repeat MULHU 0xFFFFFFFF*2 -> second result 0x00000001 in DONE one cycle after acceptance; mdu_valid_o stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op codes, issue-controller states and request type
package mdu_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    DRAIN
  } mdu_issue_state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } mdu_req_t;

endpackage

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - MDU issue/hold/writeback controller; optional result cache under MDU_RESULT_CACHE_EN
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [2:0]  ex_op_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mdu_valid_o,
  output logic [2:0]  mdu_op_o,
  output logic [31:0] mdu_rs1_o,
  output logic [31:0] mdu_rs2_o,
  input  logic        mdu_ready_i,
  input  logic [31:0] mdu_rd_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        err_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  mdu_issue_state_t r_state;
  mdu_req_t         r_req;
  logic [4:0]       r_rd;
  logic             r_mdu_valid;
  logic [31:0]      r_wb_data;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  mdu_req_t         w_ex_req;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_next;
  logic             w_timeout;
  logic             w_hit;
  logic [31:0]      w_c_data;

  assign w_ex_req   = {ex_op_i, ex_rs1_i, ex_rs2_i};
  assign w_accept   = (r_state == IDLE) && ex_valid_i && !flush_i;
  assign w_cnt_next = r_cnt + CW'(1);
  // The abort fires on the edge where the wait count reaches the limit.
  assign w_timeout  = (w_cnt_next == CW'(TIMEOUT_CYCLES));

`ifdef MDU_RESULT_CACHE_EN
  mdu_req_t    r_c_req;
  logic [31:0] r_c_data;
  logic        r_c_valid;

  assign w_hit    = r_c_valid && (r_c_req == w_ex_req);
  assign w_c_data = r_c_data;

  // Remember the last result delivered by the MDU; forget it on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_valid <= 1'b0;
      r_c_req   <= '0;
      r_c_data  <= '0;
    end else if ((r_state == WAIT) && mdu_ready_i && !flush_i) begin
      r_c_valid <= 1'b1;
      r_c_req   <= r_req;
      r_c_data  <= mdu_rd_i;
    end else if (((r_state == WAIT) || (r_state == DRAIN)) && !mdu_ready_i && w_timeout) begin
      r_c_valid <= 1'b0;
    end
  end
`else
  assign w_hit    = 1'b0;
  assign w_c_data = '0;
`endif

  // Sequencer: accept from EX, pulse the request, wait or drain, hand result to writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_rd        <= '0;
      r_mdu_valid <= 1'b0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_mdu_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req <= w_ex_req;
            r_rd  <= ex_rd_addr_i;
            if (w_hit) begin
              r_wb_data <= w_c_data;
              r_state   <= DONE;
            end else begin
              r_mdu_valid <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= flush_i ? DRAIN : WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_next;
          if (mdu_ready_i) begin
            if (flush_i) begin
              r_state <= IDLE;
            end else begin
              r_wb_data <= mdu_rd_i;
              r_state   <= DONE;
            end
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (flush_i) begin
            r_state <= DRAIN;
          end
        end
        DONE: r_state <= IDLE;
        DRAIN: begin
          r_cnt <= w_cnt_next;
          if (mdu_ready_i) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pipeline hold: busy states stall; while draining only a waiting instruction is held
  always_comb begin
    stall_o = 1'b0;
    case (r_state)
      IDLE:        stall_o = ex_valid_i && !flush_i;
      ISSUE, WAIT: stall_o = 1'b1;
      DRAIN:       stall_o = ex_valid_i;
      default:     stall_o = 1'b0;
    endcase
  end

  assign mdu_valid_o   = r_mdu_valid;
  assign mdu_op_o      = r_req.op;
  assign mdu_rs1_o     = r_req.rs1;
  assign mdu_rs2_o     = r_req.rs2;
  assign wb_valid_o    = (r_state == DONE) && !flush_i;
  assign wb_rd_addr_o  = r_rd;
  assign wb_data_o     = r_wb_data;
  assign err_timeout_o = r_err;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - self-checking bench for mdu_issue_ctrl
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [2:0]  ex_op_i = '0;
  logic [31:0] ex_rs1_i = '0;
  logic [31:0] ex_rs2_i = '0;
  logic [4:0]  ex_rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        mdu_valid_o;
  logic [2:0]  mdu_op_o;
  logic [31:0] mdu_rs1_o;
  logic [31:0] mdu_rs2_o;
  logic        mdu_ready_i = 1'b0;
  logic [31:0] mdu_rd_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        err_timeout_o;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_op_i(ex_op_i), .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .ex_rd_addr_i(ex_rd_addr_i), .flush_i(flush_i), .stall_o(stall_o),
    .mdu_valid_o(mdu_valid_o), .mdu_op_o(mdu_op_o), .mdu_rs1_o(mdu_rs1_o), .mdu_rs2_o(mdu_rs2_o),
    .mdu_ready_i(mdu_ready_i), .mdu_rd_i(mdu_rd_i),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .err_timeout_o(err_timeout_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, want);
    end
  endtask

  // RISC-V M-extension results from plain 64-bit arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MUL:    begin up = ua * ub; return up[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULHU:  begin up = ua * ub; return up[63:32]; end
      DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // MDU stand-in: answers each request after mdu_lat cycles, checks operands stay put
  int          mdu_lat = 1;
  logic        mdu_cancel = 1'b0;
  logic        pend = 1'b0;
  int          pcnt = 0;
  int          pulses = 0;
  logic [31:0] pres = '0;
  logic [2:0]  cap_op = '0;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;

  always @(negedge clk) begin
    if (rst_n && pend) begin
      chk("hold.op", {29'b0, mdu_op_o}, {29'b0, cap_op});
      chk("hold.rs1", mdu_rs1_o, cap_a);
      chk("hold.rs2", mdu_rs2_o, cap_b);
    end
    if (rst_n && mdu_valid_o) begin
      pend = 1'b1;
      pcnt = mdu_lat;
      cap_op = mdu_op_o;
      cap_a = mdu_rs1_o;
      cap_b = mdu_rs2_o;
      pres = ref_mdu(mdu_op_o, mdu_rs1_o, mdu_rs2_o);
      pulses++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mdu_ready_i) pend = 1'b0;
    mdu_ready_i = 1'b0;
    mdu_rd_i = $urandom;
    if (!rst_n || mdu_cancel) begin
      pend = 1'b0;
    end else if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        mdu_ready_i = 1'b1;
        mdu_rd_i = pres;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    ex_valid_i = 1'b1;
    ex_op_i = op;
    ex_rs1_i = a;
    ex_rs2_i = b;
    ex_rd_addr_i = rd;
    flush_i = 1'b0;
  endtask

  // Leaves the caller at the falling edge of the ISSUE cycle
  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (mdu_valid_o) ok = 1'b1;
      else tick();
    end
    chk({nm, ".issue_seen"}, {31'b0, ok}, 32'd1);
  endtask

  // One instruction from EX-valid to writeback; starts and ends just after a rising edge
  task automatic run_instr(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input int lat,
                           input logic [31:0] want);
    int k, p0;
    bit found, stall_bad, err_seen;
    mdu_lat = lat;
    present(op, a, b, rd);
    p0 = pulses;
    k = 0;
    found = 1'b0;
    stall_bad = 1'b0;
    err_seen = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (err_timeout_o) err_seen = 1'b1;
      if (wb_valid_o) found = 1'b1;
      else begin
        if (!stall_o) stall_bad = 1'b1;
        tick();
        k++;
      end
    end
    chk({nm, ".wb_seen"}, {31'b0, found}, 32'd1);
    chk({nm, ".latency"}, 32'(k), 32'(lat + 2));
    chk({nm, ".data"}, wb_data_o, want);
    chk({nm, ".rd"}, {27'b0, wb_rd_addr_o}, {27'b0, rd});
    chk({nm, ".done_stall"}, {31'b0, stall_o}, 32'd0);
    chk({nm, ".stall_held"}, {31'b0, stall_bad}, 32'd0);
    chk({nm, ".one_request"}, 32'(pulses - p0), 32'd1);
    chk({nm, ".no_err"}, {31'b0, err_seen}, 32'd0);
    tick();
    ex_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    logic [31:0] want;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int d, p0;
    bit found;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    tbl[0] = '{MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  3, 32'hFFFF_FFEB};
    tbl[1] = '{DIVU,   32'd100,       32'd7,         5'd6,  4, 32'h0000_000E};
    tbl[2] = '{REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  2, 32'hFFFF_FFFF};
    tbl[3] = '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd8,  1, 32'h4000_0000};
    tbl[4] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  5, 32'hFFFF_FFFF};
    tbl[5] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, TO, 32'h8000_0000};
    tbl[6] = '{DIVU,   32'd123,       32'd0,         5'd11, 2, 32'hFFFF_FFFF};
    tbl[7] = '{REMU,   32'd123,       32'd0,         5'd31, 3, 32'h0000_007B};
    tbl[8] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  1, 32'h0000_0000};
    tbl[9] = '{MULHU,  32'hFFFF_FFFF, 32'd2,         5'd12, 6, 32'h0000_0001};

    // reset state
    tick();
    @(negedge clk);
    chk("rst.stall", {31'b0, stall_o}, 32'd0);
    chk("rst.mdu_valid", {31'b0, mdu_valid_o}, 32'd0);
    chk("rst.wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("rst.wb_data", wb_data_o, 32'd0);
    chk("rst.err", {31'b0, err_timeout_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // table vectors, issued back-to-back
    for (int i = 0; i < 10; i++)
      run_instr($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].lat, tbl[i].want);

    // flush while idle: request ignored
    p0 = pulses;
    present(MUL, 32'd5, 32'd6, 5'd3);
    flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush.stall", {31'b0, stall_o}, 32'd0);
    tick();
    ex_valid_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush.no_issue", {31'b0, mdu_valid_o}, 32'd0);
    chk("idle_flush.pulses", 32'(pulses - p0), 32'd0);
    tick();

    // flush in the same cycle as the MDU result: discarded
    mdu_lat = 3;
    present(REMU, 32'd50, 32'd7, 5'd14);
    wait_valid("fr");
    tick();
    ex_valid_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fr.no_wb", {31'b0, wb_valid_o}, 32'd0);
    chk("fr.idle", {31'b0, stall_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("fr.no_wb2", {31'b0, wb_valid_o}, 32'd0);
    tick();

    // flush during DONE gates writeback
    mdu_lat = 2;
    present(MUL, 32'd3, 32'd4, 5'd4);
    wait_valid("fd");
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("fd.no_wb", {31'b0, wb_valid_o}, 32'd0);
    chk("fd.stall", {31'b0, stall_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    ex_valid_i = 1'b0;

    // flush five cycles into WAIT, next instruction waits out the drain
    mdu_lat = TO;
    present(DIV, 32'd1000, 32'd7, 5'd2);
    wait_valid("dr");
    for (int i = 0; i < 5; i++) tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("dr.flush_stall", {31'b0, stall_o}, 32'd1);
    tick();
    mdu_lat = 2;
    present(MUL, 32'd7, 32'hFFFF_FFFD, 5'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("dr.stall%0d", i), {31'b0, stall_o}, 32'd1);
      chk($sformatf("dr.no_issue%0d", i), {31'b0, mdu_valid_o}, 32'd0);
      chk($sformatf("dr.no_wb%0d", i), {31'b0, wb_valid_o}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("dr.accept_stall", {31'b0, stall_o}, 32'd1);
    chk("dr.accept_no_issue", {31'b0, mdu_valid_o}, 32'd0);
    chk("dr.accept_no_wb", {31'b0, wb_valid_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("dr.issue", {31'b0, mdu_valid_o}, 32'd1);
    d = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      d++;
      @(negedge clk);
      if (wb_valid_o) found = 1'b1;
    end
    chk("dr.wb_seen", {31'b0, found}, 32'd1);
    chk("dr.wb_delay", 32'(d), 32'd3);
    chk("dr.data", wb_data_o, 32'hFFFF_FFEB);
    chk("dr.rd", {27'b0, wb_rd_addr_o}, 32'd9);
    tick();
    ex_valid_i = 1'b0;

    // randomized instructions against the reference arithmetic
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      repeat ($urandom_range(0, 2)) tick();
      run_instr($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), $urandom_range(1, TO), ref_mdu(rop, ra, rb));
    end

    // hung MDU: abort TO+1 cycles after the request
    mdu_lat = 1000;
    present(DIVU, 32'd5, 32'd1, 5'd15);
    wait_valid("to");
    tick();
    ex_valid_i = 1'b0;
    d = 1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (err_timeout_o) begin
        found = 1'b1;
        chk("to.stall", {31'b0, stall_o}, 32'd0);
        chk("to.no_wb", {31'b0, wb_valid_o}, 32'd0);
      end else begin
        tick();
        d++;
      end
    end
    chk("to.err_seen", {31'b0, found}, 32'd1);
    chk("to.delay", 32'(d), 32'(TO + 1));
    mdu_cancel = 1'b1;
    @(negedge clk);
    mdu_cancel = 1'b0;
    chk("to.pulse_once", {31'b0, err_timeout_o}, 32'd0);
    chk("to.idle", {31'b0, stall_o}, 32'd0);
    tick();

    // asynchronous reset in the middle of WAIT
    mdu_lat = 1000;
    present(MULH, 32'h1234_5678, 32'd9, 5'd21);
    wait_valid("ar");
    tick();
    tick();
    tick();
    ex_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.stall", {31'b0, stall_o}, 32'd0);
    chk("ar.mdu_valid", {31'b0, mdu_valid_o}, 32'd0);
    chk("ar.op", {29'b0, mdu_op_o}, 32'd0);
    chk("ar.rs1", mdu_rs1_o, 32'd0);
    chk("ar.rs2", mdu_rs2_o, 32'd0);
    chk("ar.wb_valid", {31'b0, wb_valid_o}, 32'd0);
    chk("ar.wb_rd", {27'b0, wb_rd_addr_o}, 32'd0);
    chk("ar.wb_data", wb_data_o, 32'd0);
    chk("ar.err", {31'b0, err_timeout_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_instr("post_rst", MULHU, 32'hFFFF_FFFF, 32'd2, 5'd13, 4, 32'h0000_0001);

`ifdef MDU_RESULT_CACHE_EN
    // repeat of the last operation is served from the cache
    p0 = pulses;
    present(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd13);
    @(negedge clk);
    chk("cache.accept_stall", {31'b0, stall_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("cache.wb_valid", {31'b0, wb_valid_o}, 32'd1);
    chk("cache.data", wb_data_o, 32'h0000_0001);
    chk("cache.rd", {27'b0, wb_rd_addr_o}, 32'd13);
    chk("cache.no_issue", {31'b0, mdu_valid_o}, 32'd0);
    tick();
    ex_valid_i = 1'b0;
    tick();
    chk("cache.pulses", 32'(pulses - p0), 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

endmodule
